// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input
// in clk cycles, and flags a stalled input as a timeout.
module pwm_capture #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic             stuck_hi
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RISE,
        MEAS_HIGH,
        MEAS_LOW
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   s_d;
    logic                   rise;
    logic                   fall;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] hi_tmp;
    logic [CNT_W-1:0] hi_tmp_nx;
    logic [CNT_W-1:0] period_nx;
    logic [CNT_W-1:0] high_time_nx;
    logic             valid_nx;
    logic             timeout_nx;
    logic             stuck_hi_nx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync <= '0;
            s_d  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pwm_in};
            s_d  <= s;
        end
    end

    assign s    = sync[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    // Saturating increment; a full counter always ends in a timeout or a report.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            hi_tmp    <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
            stuck_hi  <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            hi_tmp    <= hi_tmp_nx;
            period    <= period_nx;
            high_time <= high_time_nx;
            valid     <= valid_nx;
            timeout   <= timeout_nx;
            stuck_hi  <= stuck_hi_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        hi_tmp_nx    = hi_tmp;
        period_nx    = period;
        high_time_nx = high_time;
        valid_nx     = 1'b0;
        timeout_nx   = 1'b0;
        stuck_hi_nx  = stuck_hi;
        if (!en) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nx = WAIT_RISE;
                end
                WAIT_RISE: begin
                    if (rise) begin
                        cnt_nx   = CNT_ONE;
                        state_nx = MEAS_HIGH;
                    end
                end
                MEAS_HIGH: begin
                    cnt_nx = cnt_inc;
                    if (fall) begin
                        hi_tmp_nx = cnt;
                        state_nx  = MEAS_LOW;
                    end else if (cnt == CNT_MAX) begin
                        timeout_nx  = 1'b1;
                        stuck_hi_nx = s;
                        state_nx    = WAIT_RISE;
                    end
                end
                MEAS_LOW: begin
                    cnt_nx = cnt_inc;
                    if (rise) begin
                        period_nx    = cnt;
                        high_time_nx = hi_tmp;
                        valid_nx     = 1'b1;
                        cnt_nx       = CNT_ONE;
                        state_nx     = MEAS_HIGH;
                    end else if (cnt == CNT_MAX) begin
                        timeout_nx  = 1'b1;
                        stuck_hi_nx = s;
                        state_nx    = WAIT_RISE;
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

endmodule
